// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor step per clock, LSB first.
// Computes (a - b) mod 2^WIDTH and the final borrow over WIDTH SHIFT cycles.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;

    logic             d_s;
    logic             br_next_s;
    logic [WIDTH-1:0] res_next_s;

    // One-bit full subtractor; returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

    // Current bit step and the result register as it will look after it.
    always_comb begin
        {br_next_s, d_s} = full_sub(a_r[0], b_r[0], br_r);
        res_next_s       = {d_s, res_r[WIDTH-1:1]};
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            res_r      <= '0;
            br_r       <= 1'b0;
            cnt_r      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        res_r   <= '0;
                        br_r    <= 1'b0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    res_r <= res_next_s;
                    br_r  <= br_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    // The last bit lands directly in the output registers.
                    if (cnt_r == LAST_BIT) begin
                        diff       <= res_next_s;
                        borrow_out <= br_next_s;
                        busy       <= 1'b0;
                        state_r    <= DONE;
                    end else begin
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): timeline reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    logic         done;

    int checks;
    int failures;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: k counts edges since the accepted start edge.
    logic         m_active;
    int           m_k;
    logic [W-1:0] m_pd;
    logic         m_pb;
    logic [W-1:0] m_diff;
    logic         m_borrow;
    logic         m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_pd     <= '0;
            m_pb     <= 1'b0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_done   <= 1'b0;
        end else if (!m_active) begin
            m_done <= 1'b0;
            if (start) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_pd     <= W'((int'(a) - int'(b)) & ((1 << W) - 1));
                m_pb     <= (a < b);
            end
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == W) begin
                m_diff   <= m_pd;
                m_borrow <= m_pb;
            end
            if (m_k + 1 == W + 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    logic cmp_en;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {31'd0, busy}, {31'd0, (m_active && m_k < W)});
            chk("model_done", {31'd0, done}, {31'd0, m_done});
            chk("model_diff", {24'd0, diff}, {24'd0, m_diff});
            chk("model_borrow", {31'd0, borrow_out}, {31'd0, m_borrow});
            chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb, input string nm);
        int lat;
        int bcnt;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 50) begin
            if (busy) bcnt = bcnt + 1;
            @(negedge clk);
            lat = lat + 1;
        end
        chk({nm, "_latency"}, lat, 32'd9);
        chk({nm, "_busy_cycles"}, bcnt, 32'd8);
        chk({nm, "_diff"}, {24'd0, diff}, {24'd0, ed});
        chk({nm, "_borrow"}, {31'd0, borrow_out}, {31'd0, eb});
    endtask

    initial begin
        int lat;
        int dcnt;
        checks   = 0;
        failures = 0;
        cmp_en   = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        #12;
        chk("reset_diff", {24'd0, diff}, 32'd0);
        chk("reset_borrow", {31'd0, borrow_out}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        run_op(8'h5A, 8'h23, 8'h37, 1'b0, "op_5a_23");
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, "op_00_01");
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, "op_10_20");
        repeat (3) @(negedge clk);
        chk("hold_diff", {24'd0, diff}, 32'h0000_00F0);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "op_ff_ff");
        run_op(8'h00, 8'h00, 8'h00, 1'b0, "op_00_00");
        run_op(8'hC8, 8'h64, 8'h64, 1'b0, "op_c8_64");

        // Re-pulses of start in SHIFT (3rd cycle) and in the DONE-state cycle.
        @(negedge clk);
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'h00;
        b = 8'hFF;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            start = (i == 2 || i == 8);
            if (done) dcnt = dcnt + 1;
            if (done) chk("ignore_diff", {24'd0, diff}, 32'h0000_007F);
            if (done) chk("ignore_borrow", {31'd0, borrow_out}, 32'd0);
            @(negedge clk);
        end
        start = 1'b0;
        chk("ignore_done_count", dcnt, 32'd1);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        a = 8'h44;
        b = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_diff", {24'd0, diff}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_borrow", {31'd0, borrow_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) dcnt = dcnt + 1;
        end
        chk("no_done_after_rst", dcnt, 32'd0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, "op_03_05");

        // Back-to-back with start held high and random operands.
        @(negedge clk);
        start = 1'b1;
        dcnt = 0;
        lat = 0;
        while (dcnt < 1000 && lat < 20000) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            @(negedge clk);
            lat = lat + 1;
            if (done) dcnt = dcnt + 1;
        end
        start = 1'b0;
        chk("b2b_op_count", dcnt, 32'd1000);
        chk("b2b_cycle_count", lat, 32'd10000);
        repeat (15) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
